// File: rtl/bsg_dff_gatestack_loader.sv
// Sequencer that writes a masked word into a bsg_dff_gatestack, one registered strobe per bit, LSB first.
// Define BSG_GATESTACK_LOADER_SKIP_EN to skip bits whose last strobed value already matches the request.
module bsg_dff_gatestack_loader #(
    parameter int width_p = 16,
    parameter int setup_p = 1,
    parameter int pulse_p = 1,
    parameter int hold_p  = 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    input  logic [width_p-1:0] mask_i,
    output logic [width_p-1:0] gs_data_o,
    output logic [width_p-1:0] gs_clk_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int max_sp_lp = (setup_p > pulse_p) ? setup_p : pulse_p;
    localparam int max_lp    = (max_sp_lp > hold_p) ? max_sp_lp : hold_p;
    localparam int cnt_w_lp  = $clog2(max_lp + 1);

    if (setup_p < 1 || pulse_p < 1 || hold_p < 1) begin : g_bad_param
        $error("bsg_dff_gatestack_loader: setup_p, pulse_p and hold_p must all be >= 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_e;

    state_e                state_r, state_n;
    logic [cnt_w_lp-1:0]   cnt_r, cnt_n;
    logic [width_p-1:0]    pend_r, pend_n;
    logic [width_p-1:0]    cur_bit;
    logic [width_p-1:0]    accept_mask;
    logic [width_p-1:0]    gs_data_n, gs_clk_n;
    logic                  done_n, ready_n, busy_n;

    // One-hot of the bit currently being serviced: lowest set bit of the pending mask.
    assign cur_bit = pend_r & (~pend_r + width_p'(1));

`ifdef BSG_GATESTACK_LOADER_SKIP_EN
    logic [width_p-1:0] shadow_r, shadow_v_r;

    assign accept_mask = mask_i & ~(shadow_v_r & ~(data_i ^ shadow_r));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            shadow_r   <= '0;
            shadow_v_r <= '0;
        end else if (state_r == SETUP && state_n == PULSE) begin
            shadow_r   <= (shadow_r & ~cur_bit) | (gs_data_o & cur_bit);
            shadow_v_r <= shadow_v_r | cur_bit;
        end
    end
`else
    assign accept_mask = mask_i;
`endif

    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        pend_n    = pend_r;
        gs_data_n = gs_data_o;
        gs_clk_n  = '0;
        done_n    = 1'b0;
        unique case (state_r)
            IDLE: begin
                if (v_i && ready_o) begin
                    gs_data_n = data_i;
                    pend_n    = accept_mask;
                    cnt_n     = '0;
                    if (accept_mask == '0) done_n  = 1'b1;
                    else                   state_n = SETUP;
                end
            end
            SETUP: begin
                if (cnt_r == cnt_w_lp'(setup_p - 1)) begin
                    state_n  = PULSE;
                    cnt_n    = '0;
                    gs_clk_n = cur_bit;
                end else begin
                    cnt_n = cnt_r + 1'b1;
                end
            end
            PULSE: begin
                if (cnt_r == cnt_w_lp'(pulse_p - 1)) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end else begin
                    cnt_n    = cnt_r + 1'b1;
                    gs_clk_n = cur_bit;
                end
            end
            HOLD: begin
                if (cnt_r == cnt_w_lp'(hold_p - 1)) begin
                    cnt_n  = '0;
                    pend_n = pend_r & ~cur_bit;
                    if ((pend_r & ~cur_bit) == '0) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = SETUP;
                    end
                end else begin
                    cnt_n = cnt_r + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == IDLE);
        busy_n  = (state_n != IDLE);
    end

    // All outputs come straight from flops so the strobes cannot glitch.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            pend_r    <= '0;
            gs_data_o <= '0;
            gs_clk_o  <= '0;
            done_o    <= 1'b0;
            ready_o   <= 1'b1;
            busy_o    <= 1'b0;
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            pend_r    <= pend_n;
            gs_data_o <= gs_data_n;
            gs_clk_o  <= gs_clk_n;
            done_o    <= done_n;
            ready_o   <= ready_n;
            busy_o    <= busy_n;
        end
    end

endmodule

// File: tb/tb_bsg_dff_gatestack_loader.sv
// Bench for bsg_dff_gatestack_loader: two instances (default and 2/3/2 timing) checked cycle by cycle
// against a schedule computed from the request; a behavioural gatestack captures the strobes.
module tb_bsg_dff_gatestack_loader;

    localparam int SP[2] = '{1, 2};
    localparam int PP[2] = '{1, 3};
    localparam int HP[2] = '{1, 2};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        v    [2];
    logic [15:0] din  [2];
    logic [15:0] min  [2];
    logic        rdy  [2];
    logic        busy [2];
    logic        done [2];
    logic [15:0] gdat [2];
    logic [15:0] gclk [2];
    wire  [15:0] gsq  [2];

    int total = 0;
    int passed = 0;
    int fails = 0;

    logic [15:0] exp_o    [2];
    logic [15:0] cur_data [2];
    logic [15:0] sh       [2];
    logic [15:0] shv      [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bsg_dff_gatestack_loader #(
            .width_p(16), .setup_p(SP[g]), .pulse_p(PP[g]), .hold_p(HP[g])
        ) dut (
            .clk_i(clk), .reset_n_i(rst_n), .v_i(v[g]), .ready_o(rdy[g]),
            .data_i(din[g]), .mask_i(min[g]), .gs_data_o(gdat[g]), .gs_clk_o(gclk[g]),
            .busy_o(busy[g]), .done_o(done[g])
        );
        for (genvar b = 0; b < 16; b++) begin : g_bit
            logic q = 1'b0;
            always @(posedge gclk[g][b]) q <= gdat[g][b];
            assign gsq[g][b] = q;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and checks every cycle up to and including its done cycle.
    task automatic run_req(input int g, input logic [15:0] d, input logic [15:0] m, input bit hold_v);
        logic [15:0] eff;
        logic [15:0] exp_clk;
        int bits[$];
        int S, P, L, kdone;
        S = SP[g];
        P = PP[g];
        L = SP[g] + PP[g] + HP[g];
        eff = m;
`ifdef BSG_GATESTACK_LOADER_SKIP_EN
        eff = m & ~(shv[g] & ~(d ^ sh[g]));
`endif
        for (int b = 0; b < 16; b++) if (eff[b]) bits.push_back(b);
        kdone = bits.size() * L + 1;
        v[g] = 1'b1;
        din[g] = d;
        min[g] = m;
        for (int k = 1; k <= kdone; k++) begin
            step();
            exp_clk = '0;
            foreach (bits[j]) if (k >= j*L + S + 1 && k <= j*L + S + P) exp_clk[bits[j]] = 1'b1;
            check($sformatf("g%0d strobe k=%0d", g, k), gclk[g], exp_clk);
            check($sformatf("g%0d done k=%0d", g, k), done[g], k == kdone);
            check($sformatf("g%0d ready k=%0d", g, k), rdy[g], k == kdone);
            check($sformatf("g%0d busy k=%0d", g, k), busy[g], k < kdone);
            check($sformatf("g%0d gs_data k=%0d", g, k), gdat[g], d);
            if (k < kdone) begin
                v[g] = hold_v;
                din[g] = 16'($urandom);
                min[g] = 16'($urandom);
            end
        end
        foreach (bits[j]) begin
            exp_o[g][bits[j]] = d[bits[j]];
            sh[g][bits[j]] = d[bits[j]];
            shv[g][bits[j]] = 1'b1;
        end
        cur_data[g] = d;
        check($sformatf("g%0d gatestack", g), gsq[g], exp_o[g]);
    endtask

    task automatic idle(input int g, input int n);
        v[g] = 1'b0;
        for (int i = 0; i < n; i++) begin
            din[g] = 16'($urandom);
            min[g] = 16'($urandom);
            step();
            check($sformatf("g%0d idle ready", g), rdy[g], 1);
            check($sformatf("g%0d idle done", g), done[g], 0);
            check($sformatf("g%0d idle strobe", g), gclk[g], 0);
            check($sformatf("g%0d idle gs_data", g), gdat[g], cur_data[g]);
        end
    endtask

    initial begin
        logic [15:0] dd;
        for (int g = 0; g < 2; g++) begin
            v[g] = 1'b0; din[g] = '0; min[g] = '0;
            exp_o[g] = '0; cur_data[g] = '0; sh[g] = '0; shv[g] = '0;
        end
        #1 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        for (int g = 0; g < 2; g++) begin
            check($sformatf("g%0d reset ready", g), rdy[g], 1);
            check($sformatf("g%0d reset busy", g), busy[g], 0);
            check($sformatf("g%0d reset done", g), done[g], 0);
            check($sformatf("g%0d reset strobe", g), gclk[g], 0);
            check($sformatf("g%0d reset gs_data", g), gdat[g], 0);
        end

        // Single bit, full word, then wide spacing on the second instance.
        run_req(0, 16'h0001, 16'h0001, 1'b0);
        idle(0, 2);
        run_req(0, 16'hA5A5, 16'hFFFF, 1'b0);
        idle(0, 2);
        run_req(1, 16'($urandom), 16'h8001, 1'b0);
        idle(1, 2);

        // Empty mask, v held while busy, and accepts on the done cycle.
        run_req(0, 16'($urandom), 16'h0000, 1'b1);
        run_req(0, 16'($urandom), 16'h0010, 1'b1);
        run_req(0, 16'($urandom), 16'h0000, 1'b1);
        run_req(0, 16'($urandom), 16'h0300, 1'b0);
        idle(0, 3);

        for (int i = 0; i < 6; i++) begin
            int g;
            logic [15:0] m;
            g = i % 2;
            m = (i % 3 == 0) ? 16'($urandom & $urandom & $urandom) : 16'($urandom);
            run_req(g, 16'($urandom), m, 1'($urandom));
            run_req(g, 16'($urandom), 16'($urandom & $urandom), 1'($urandom));
            idle(g, 2);
        end

        // Reset during the first strobe of a request.
        dd = (~sh[0] & 16'h0006) | (16'($urandom) & ~16'h0006);
        v[0] = 1'b1; din[0] = dd; min[0] = 16'h0006;
        step();
        v[0] = 1'b0;
        check("rst setup strobe", gclk[0], 16'h0000);
        step();
        check("rst pulse strobe", gclk[0], 16'h0002);
        #2 rst_n = 1'b0;
        #1;
        check("rst async strobe", gclk[0], 16'h0000);
        repeat (2) begin
            step();
            check("rst held strobe", gclk[0], 16'h0000);
        end
        rst_n = 1'b1;
        exp_o[0][1] = dd[1];
        for (int g = 0; g < 2; g++) begin
            cur_data[g] = '0; sh[g] = '0; shv[g] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            step();
            check("post-rst ready", rdy[0], 1);
            check("post-rst busy", busy[0], 0);
            check("post-rst done", done[0], 0);
            check("post-rst strobe", gclk[0], 16'h0000);
            check("post-rst gs_data", gdat[0], 16'h0000);
        end
        check("post-rst gatestack g0", gsq[0], exp_o[0]);
        check("post-rst gatestack g1", gsq[1], exp_o[1]);

`ifdef BSG_GATESTACK_LOADER_SKIP_EN
        run_req(0, 16'h00FF, 16'hFFFF, 1'b1);
        run_req(0, 16'h01FF, 16'hFFFF, 1'b0);
        idle(0, 2);
`endif
        run_req(0, 16'($urandom), 16'($urandom), 1'b0);
        idle(0, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
